// File: rtl/ibex_cluster_pkg.sv
// Shared types for the Ibex cluster TL-UL arbiter.
// TL-UL bundles, host index type and round-robin pick helper.
package ibex_cluster_pkg;

  localparam int unsigned NumHostsDefault = 2;
  localparam int unsigned DepthDefault    = 4;
  localparam int unsigned MaxHosts        = 32;
  localparam int unsigned MaxHostIdW      = 5;

  typedef logic [MaxHostIdW-1:0] host_id_t;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [6:0]  a_cmd_intg;
    logic [6:0]  a_data_intg;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [6:0]  d_rsp_intg;
    logic [6:0]  d_data_intg;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // First requester at or above ptr, wrapping at n; ptr if none.
  function automatic host_id_t rr_pick(
    input logic [MaxHosts-1:0] req,
    input host_id_t            ptr,
    input int unsigned         n
  );
    host_id_t win;
    host_id_t idx;
    logic     found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxHosts; k++) begin
      idx = host_id_t'((32'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ibex_cluster_rr_arb.sv
// Round-robin host selection with grant lock.
// Lock holds the winner while the device stalls the A channel.
module ibex_cluster_rr_arb
  import ibex_cluster_pkg::*;
#(
  parameter int unsigned NumHosts = NumHostsDefault,
  parameter int unsigned HostIdW  = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumHosts-1:0] valid_i,
  input  logic [NumHosts-1:0] en_i,
  input  logic               hs_i,
  input  logic               stall_i,
  output logic [NumHosts-1:0] req_o,
  output logic [HostIdW-1:0] winner_o
);

  logic [HostIdW-1:0] ptr_q, ptr_d;
  logic [HostIdW-1:0] lock_id_q, lock_id_d;
  logic               lock_q, lock_d;
  logic [HostIdW-1:0] pick;

  assign req_o = valid_i & en_i;
  assign pick  = HostIdW'(rr_pick(MaxHosts'(req_o),
                                  host_id_t'(ptr_q), NumHosts));

  always_comb begin
    winner_o  = lock_q ? lock_id_q : pick;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (hs_i) begin
      lock_d = 1'b0;
      ptr_d  = (winner_o == HostIdW'(NumHosts - 1)) ?
               '0 : winner_o + HostIdW'(1);
    end else if (stall_i) begin
      lock_d    = 1'b1;
      lock_id_d = winner_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with optional empty pass-through.
// Occupancy reported on depth_o.
module prim_fifo_sync #(
  parameter int unsigned Width = 1,
  parameter bit          Pass  = 1'b0,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  depth_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             empty, full, bypass, push, pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(Depth));
  assign wready_o = ~full;
  assign rvalid_o = ~empty | (Pass & wvalid_i);
  assign rdata_o  = (Pass && empty) ? wdata_i : mem_q[rptr_q];
  assign depth_o  = cnt_q;

  assign bypass = Pass & empty & wvalid_i & rready_i;
  assign push   = wvalid_i & ~full & ~bypass;
  assign pop    = rready_i & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ibex_cluster_tl_arb.sv
// N-host to 1-device TL-UL arbiter for a multi-hart Ibex cluster.
// In-order responses are steered back via a tag FIFO of host indices.
module ibex_cluster_tl_arb
  import ibex_cluster_pkg::*;
#(
  parameter int unsigned NumHosts = NumHostsDefault,
  parameter int unsigned Depth    = DepthDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumHosts-1:0] host_en_i,
  input  tl_h2d_t             host_tl_h_i [NumHosts],
  output tl_d2h_t             host_tl_h_o [NumHosts],
  output tl_h2d_t             dev_tl_h_o,
  input  tl_d2h_t             dev_tl_h_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned HostIdW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int unsigned CntW    = $clog2(Depth + 1);

  logic [NumHosts-1:0] valid, req;
  logic [HostIdW-1:0]  winner, head;
  logic [CntW-1:0]     occ;
  logic                fifo_wready, fifo_rvalid;
  logic                full, empty, a_vld, hs, stall, pop;
  logic                busy_q, err_q;

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      valid[i] = host_tl_h_i[i].a_valid;
    end
  end

  ibex_cluster_rr_arb #(
    .NumHosts (NumHosts),
    .HostIdW  (HostIdW)
  ) u_rr_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid),
    .en_i     (host_en_i),
    .hs_i     (hs),
    .stall_i  (stall),
    .req_o    (req),
    .winner_o (winner)
  );

  assign full  = ~fifo_wready;
  assign empty = ~fifo_rvalid;
  assign a_vld = req[winner] & ~full;
  assign hs    = a_vld & dev_tl_h_i.a_ready;
  assign stall = a_vld & ~dev_tl_h_i.a_ready;
  assign pop   = dev_tl_h_i.d_valid & host_tl_h_i[head].d_ready;

  prim_fifo_sync #(
    .Width (HostIdW),
    .Pass  (1'b0),
    .Depth (Depth)
  ) u_tag_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wvalid_i (hs),
    .wready_o (fifo_wready),
    .wdata_i  (winner),
    .rvalid_o (fifo_rvalid),
    .rready_i (pop),
    .rdata_o  (head),
    .depth_o  (occ)
  );

  always_comb begin
    dev_tl_h_o         = host_tl_h_i[winner];
    dev_tl_h_o.a_valid = a_vld;
    dev_tl_h_o.d_ready = empty ? 1'b1 : host_tl_h_i[head].d_ready;
  end

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      host_tl_h_o[i] = dev_tl_h_i;
      host_tl_h_o[i].a_ready = (HostIdW'(i) == winner) &
                               dev_tl_h_i.a_ready & ~full;
      host_tl_h_o[i].d_valid = (HostIdW'(i) == head) &
                               dev_tl_h_i.d_valid & ~empty;
    end
  end

  // Beats arriving with no outstanding tag are sunk and flagged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= (occ != '0);
      err_q  <= dev_tl_h_i.d_valid & empty;
    end
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_ibex_cluster_tl_arb.sv
// Directed bench for ibex_cluster_tl_arb (2 hosts, depth 4).
module tb_ibex_cluster_tl_arb;
  import ibex_cluster_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] en;
  tl_h2d_t    host_i [2];
  tl_d2h_t    host_o [2];
  tl_h2d_t    dev_o;
  tl_d2h_t    dev_i;
  logic       busy;
  logic       err;

  int n_chk;
  int n_fail;

  ibex_cluster_tl_arb #(
    .NumHosts (2),
    .Depth    (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .host_en_i   (en),
    .host_tl_h_i (host_i),
    .host_tl_h_o (host_o),
    .dev_tl_h_o  (dev_o),
    .dev_tl_h_i  (dev_i),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic hreq(input int i, input logic v,
                      input logic [31:0] addr);
    host_i[i].a_valid   = v;
    host_i[i].a_opcode  = Get;
    host_i[i].a_address = addr;
    host_i[i].a_source  = 8'(8'h10 + i);
    host_i[i].a_mask    = 4'hf;
  endtask

  task automatic drsp(input logic v, input logic [31:0] data);
    dev_i.d_valid  = v;
    dev_i.d_opcode = AccessAckData;
    dev_i.d_data   = data;
  endtask

  task automatic idle_all();
    hreq(0, 1'b0, 32'h0);
    hreq(1, 1'b0, 32'h0);
    drsp(1'b0, 32'h0);
    dev_i.a_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    en     = 2'b11;
    host_i[0] = '0;
    host_i[1] = '0;
    host_i[0].d_ready = 1'b1;
    host_i[1].d_ready = 1'b1;
    dev_i = '0;

    // Reset state
    do_reset();
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_dev_avalid", dev_o.a_valid, 0);
    chk("rst_aready", {host_o[1].a_ready, host_o[0].a_ready}, 0);
    chk("rst_dvalid", {host_o[1].d_valid, host_o[0].d_valid}, 0);

    // Single host: 4 Gets, responses 2 cycles later
    dev_i.a_ready = 1'b1;
    hreq(0, 1'b1, 32'h100);
    settle();
    chk("s_c0_avalid", dev_o.a_valid, 1);
    chk("s_c0_addr", dev_o.a_address, 32'h100);
    chk("s_c0_aready", host_o[0].a_ready, 1);
    chk("s_c0_busy", busy, 0);
    tick();
    hreq(0, 1'b1, 32'h104);
    settle();
    chk("s_c1_addr", dev_o.a_address, 32'h104);
    tick();
    hreq(0, 1'b1, 32'h108);
    drsp(1'b1, 32'hd0);
    settle();
    chk("s_c2_dv", {host_o[1].d_valid, host_o[0].d_valid}, 2'b01);
    chk("s_c2_data", host_o[0].d_data, 32'hd0);
    chk("s_c2_busy", busy, 1);
    tick();
    hreq(0, 1'b1, 32'h10c);
    drsp(1'b1, 32'hd1);
    settle();
    chk("s_c3_addr", dev_o.a_address, 32'h10c);
    chk("s_c3_dv", host_o[0].d_valid, 1);
    chk("s_c3_busy", busy, 1);
    tick();
    hreq(0, 1'b0, 32'h0);
    drsp(1'b1, 32'hd2);
    settle();
    chk("s_c4_avalid", dev_o.a_valid, 0);
    chk("s_c4_dv", host_o[0].d_valid, 1);
    chk("s_c4_busy", busy, 1);
    tick();
    drsp(1'b1, 32'hd3);
    settle();
    chk("s_c5_dv", host_o[0].d_valid, 1);
    chk("s_c5_data", host_o[0].d_data, 32'hd3);
    chk("s_c5_busy", busy, 1);
    tick();
    drsp(1'b0, 32'h0);
    settle();
    chk("s_c6_busy", busy, 1);
    chk("s_c6_err", err, 0);
    tick();
    settle();
    chk("s_c7_busy", busy, 0);

    // Round-robin: both hosts request every cycle
    do_reset();
    dev_i.a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hreq(0, 1'b1, 32'h200 + 32'(k));
      hreq(1, 1'b1, 32'h300 + 32'(k));
      settle();
      chk("rr_src", dev_o.a_source, (k % 2 == 0) ? 32'h10 : 32'h11);
      chk("rr_aready", {host_o[1].a_ready, host_o[0].a_ready},
          (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    hreq(0, 1'b0, 32'h0);
    hreq(1, 1'b0, 32'h0);
    dev_i.d_rsp_intg = 7'h2b;
    for (int k = 0; k < 4; k++) begin
      drsp(1'b1, 32'he0 + 32'(k));
      settle();
      chk("rr_route", {host_o[1].d_valid, host_o[0].d_valid},
          (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    chk("rr_rsp_intg", host_o[1].d_rsp_intg, 32'h2b);
    drsp(1'b0, 32'h0);
    dev_i.d_rsp_intg = 7'h0;

    // Lock: host1 stalled 3 cycles while host0 also requests
    do_reset();
    hreq(1, 1'b1, 32'h300);
    host_i[1].a_cmd_intg = 7'h5a;
    settle();
    chk("lk_l0_src", dev_o.a_source, 32'h11);
    chk("lk_l0_aready", host_o[1].a_ready, 0);
    tick();
    hreq(0, 1'b1, 32'h200);
    for (int k = 1; k < 3; k++) begin
      settle();
      chk("lk_hold_src", dev_o.a_source, 32'h11);
      chk("lk_hold_addr", dev_o.a_address, 32'h300);
      chk("lk_hold_intg", dev_o.a_cmd_intg, 32'h5a);
      tick();
    end
    dev_i.a_ready = 1'b1;
    settle();
    chk("lk_l3_src", dev_o.a_source, 32'h11);
    chk("lk_l3_aready", {host_o[1].a_ready, host_o[0].a_ready}, 2'b10);
    tick();
    hreq(1, 1'b0, 32'h0);
    host_i[1].a_cmd_intg = 7'h0;
    settle();
    chk("lk_l4_src", dev_o.a_source, 32'h10);
    chk("lk_l4_aready", host_o[0].a_ready, 1);

    // Full: 4 handshakes, no responses
    do_reset();
    dev_i.a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hreq(0, 1'b1, 32'h400 + 32'(k));
      settle();
      chk("fu_fill", host_o[0].a_ready, 1);
      tick();
    end
    hreq(1, 1'b1, 32'h500);
    settle();
    chk("fu_avalid", dev_o.a_valid, 0);
    chk("fu_aready", {host_o[1].a_ready, host_o[0].a_ready}, 0);
    tick();
    drsp(1'b1, 32'hf0);
    settle();
    chk("fu_pop_avalid", dev_o.a_valid, 0);
    chk("fu_pop_dv", host_o[0].d_valid, 1);
    tick();
    drsp(1'b0, 32'h0);
    settle();
    chk("fu_5th_avalid", dev_o.a_valid, 1);
    chk("fu_5th_src", dev_o.a_source, 32'h11);
    chk("fu_5th_aready", host_o[1].a_ready, 1);

    // Disabled host and unexpected response
    do_reset();
    en = 2'b01;
    dev_i.a_ready = 1'b1;
    hreq(1, 1'b1, 32'h600);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("dis_avalid", dev_o.a_valid, 0);
      chk("dis_aready", host_o[1].a_ready, 0);
      tick();
    end
    hreq(1, 1'b0, 32'h0);
    drsp(1'b1, 32'hbad);
    settle();
    chk("er_dready", dev_o.d_ready, 1);
    chk("er_dv", {host_o[1].d_valid, host_o[0].d_valid}, 0);
    chk("er_pre", err, 0);
    tick();
    drsp(1'b0, 32'h0);
    settle();
    chk("er_pulse", err, 1);
    tick();
    settle();
    chk("er_clear", err, 0);
    en = 2'b11;

    // Reset with two requests outstanding
    do_reset();
    dev_i.a_ready = 1'b1;
    hreq(0, 1'b1, 32'h700);
    tick();
    hreq(0, 1'b1, 32'h704);
    tick();
    hreq(0, 1'b0, 32'h0);
    settle();
    chk("rm_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drsp(1'b1, 32'hc0);
    settle();
    chk("rm_busy_post", busy, 0);
    chk("rm_dv0", {host_o[1].d_valid, host_o[0].d_valid}, 0);
    chk("rm_dready", dev_o.d_ready, 1);
    tick();
    drsp(1'b1, 32'hc1);
    settle();
    chk("rm_err0", err, 1);
    chk("rm_dv1", {host_o[1].d_valid, host_o[0].d_valid}, 0);
    tick();
    drsp(1'b0, 32'h0);
    settle();
    chk("rm_err1", err, 1);
    tick();
    settle();
    chk("rm_err_clr", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
